// File: rtl/reg_load_pkg.sv
// Shared types and constants for the register load controller.
// Header layout: [31:24] opcode, [23:16] ignored, [15:8] count, [7:0] start index.
package reg_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] OPC_LOAD = 8'hA5;

  localparam int HDR_OPC_LSB = 24;
  localparam int HDR_RSV_LSB = 16;
  localparam int HDR_CNT_LSB = 8;
  localparam int HDR_IDX_LSB = 0;

endpackage

// File: rtl/reg_load_ctrl_if.sv
// Upstream word stream plus register-load outputs of reg_load_ctrl.
// Slave is the controller, master is whoever feeds it and observes the loads.
interface reg_load_ctrl_if
  import reg_load_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
);
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic [NUM_REGS-1:0] r_enable;
  logic [DATA_W-1:0]   data_out;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output in_valid, in_data,
    input  in_ready, r_enable, data_out, busy, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, r_enable, data_out, busy, done, err
  );
endinterface

// File: rtl/reg_load_hdr_dec.sv
// Combinational header decode: opcode check, count/index fields and range legality.
// End is computed at 9 bits so index + count can never wrap into a legal range.
module reg_load_hdr_dec
  import reg_load_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic [31:0] i_hdr,
  output logic        o_is_load,
  output logic [7:0]  o_cnt,
  output logic [7:0]  o_idx,
  output logic        o_legal
);
  logic [8:0] w_end;
  logic       w_unused_rsv;

  assign o_is_load    = (i_hdr[HDR_OPC_LSB +: 8] == OPC_LOAD);
  assign o_cnt        = i_hdr[HDR_CNT_LSB +: 8];
  assign o_idx        = i_hdr[HDR_IDX_LSB +: 8];
  assign w_end        = {1'b0, o_idx} + {1'b0, o_cnt};
  assign o_legal      = (w_end <= 9'(NUM_REGS));
  assign w_unused_rsv = ^i_hdr[HDR_RSV_LSB +: 8];
endmodule

// File: rtl/reg_load_ctrl.sv
// Header-driven loader: writes a burst of payload words into consecutive target registers.
// Enable/data appear one cycle after each accepted word; in_ready drops only in the DONE cycle.
module reg_load_ctrl
  import reg_load_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
) (
  input  logic           clock,
  input  logic           reset,
  reg_load_ctrl_if.slave bus
);
  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_ptr;
  logic [7:0]          r_rem;
  logic [NUM_REGS-1:0] r_enable;
  logic [NUM_REGS-1:0] w_onehot;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;
  logic                w_xfer;
  logic                w_ready;
  logic                w_busy;
  logic                w_done;
  logic                w_is_load;
  logic                w_legal;
  logic [7:0]          w_cnt;
  logic [7:0]          w_idx;

  assign w_xfer = bus.in_valid & w_ready;

  reg_load_hdr_dec #(
    .NUM_REGS (NUM_REGS)
  ) u_hdr_dec (
    .i_hdr     (bus.in_data[31:0]),
    .o_is_load (w_is_load),
    .o_cnt     (w_cnt),
    .o_idx     (w_idx),
    .o_legal   (w_legal)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_is_load) begin
          if (w_legal) w_next = (w_cnt == 8'd0) ? ST_DONE : ST_LOAD;
          else         w_next = (w_cnt == 8'd0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_LOAD:  if (w_xfer && r_rem == 8'd1) w_next = ST_DONE;
      ST_DRAIN: if (w_xfer && r_rem == 8'd1) w_next = ST_IDLE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: w_busy = 1'b0;
      ST_DONE: begin
        w_ready = 1'b0;
        w_done  = 1'b1;
      end
      default: ;
    endcase
  end

  // ptr is always below NUM_REGS while in LOAD, so exactly one bit is set.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_ptr == 8'(i)) w_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr    <= '0;
      r_rem    <= '0;
      r_enable <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_enable <= '0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (!w_is_load) begin
              r_err <= 1'b1;
            end else if (!w_legal) begin
              r_err <= 1'b1;
              r_rem <= w_cnt;
            end else begin
              r_ptr <= w_idx;
              r_rem <= w_cnt;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_data   <= bus.in_data;
            r_enable <= w_onehot;
            r_ptr    <= r_ptr + 8'd1;
            r_rem    <= r_rem - 8'd1;
          end
        end
        ST_DRAIN: if (w_xfer) r_rem <= r_rem - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.err      = r_err;
  assign bus.r_enable = r_enable;
  assign bus.data_out = r_data;
endmodule

// File: doc/reg_load_ctrl.md
REG_LOAD_CTRL -- requirements
Module: reg_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 32-bit target registers driven (1..255).
REQ-002 SHALL have parameter DATA_W, default 32, payload and register width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_data  input  DATA_W  upstream word, header or payload.
REQ-007 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have port r_enable  output  NUM_REGS  one-hot load enables, one per target register.
REQ-009 SHALL have port data_out  output  DATA_W  shared data bus to all target register inputs.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a legal load completes.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a rejected header.

Function
REQ-013 SHALL transfer a word only when in_valid and in_ready are both high at a rising edge.
REQ-014 SHALL decode the header as: [31:24] opcode, [15:8] count, [7:0] start index; bits [23:16] are ignored.
REQ-015 SHALL treat opcode 0xA5 as LOAD; any other opcode pulses err one cycle after acceptance and stays in IDLE.
REQ-016 SHALL compute end = index + count at 9-bit width, with no wrap; the header is legal only if end <= NUM_REGS.
REQ-017 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-018 In IDLE, a legal LOAD header with count > 0 SHALL move to LOAD, load ptr = index, and load remaining = count.
REQ-019 In IDLE, a legal LOAD header with count = 0 SHALL move directly to DONE.
REQ-020 In IDLE, a LOAD header with end > NUM_REGS SHALL pulse err, load remaining = count, and move to DRAIN (or stay in IDLE if count = 0).
REQ-021 In LOAD, each accepted payload word SHALL register data_out = word and r_enable = one-hot(ptr) on the next cycle, then increment ptr and decrement remaining.
REQ-022 On the last payload word (remaining = 1), LOAD SHALL move to DONE.
REQ-023 DRAIN SHALL accept and discard remaining payload words with r_enable held at 0, then return to IDLE with no done pulse.
REQ-024 DONE SHALL last exactly one cycle, drive done = 1 and in_ready = 0, then return to IDLE.
REQ-025 in_ready SHALL be 1 in IDLE, LOAD and DRAIN.
REQ-026 Latency from payload acceptance to the r_enable/data_out pulse SHALL be exactly 1 cycle; r_enable SHALL be high for one cycle per word and at most one bit high at any time.
REQ-027 data_out SHALL hold its last value when r_enable is 0.
REQ-028 in_valid low in LOAD/DRAIN SHALL stall with no timeout; state, ptr and remaining are held.
REQ-029 The final-word r_enable pulse and the done pulse SHALL occur in the same cycle.

Reset
REQ-030 On reset, state SHALL be IDLE; r_enable, data_out, done, err and busy SHALL be 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-031 Reset mid-LOAD or mid-DRAIN SHALL abandon the transfer; no further enables are issued and registers already written are not touched.
REQ-032 reset SHALL take priority over a simultaneous in_valid/in_ready transfer; the word is dropped.

Structure
REQ-033 Package reg_load_pkg SHALL hold the state enum, OPC_LOAD = 8'hA5, and the header field bit positions.
REQ-034 Header decode (opcode check, end computation, legality) SHALL be a combinational sub-module reg_load_hdr_dec.
REQ-035 The FSM, ptr/remaining counters and output registers SHALL be in reg_load_ctrl.

Verification
REQ-036 Header 0xA5000201 then payloads 0x11, 0x22 -> r_enable 0b0010 with data 0x11, then 0b0100 with data 0x22; done coincides with the second pulse.
REQ-037 Header 0xA5000000 -> no enables; done one cycle after acceptance; in_ready low for exactly one cycle.
REQ-038 Header 0xA5000303 (end = 6 > 4) then 3 payloads -> err pulse; all words accepted; r_enable stays 0; no done.
REQ-039 Header 0x5A000100 -> err pulse; state stays IDLE; the next word is decoded as a header.
REQ-040 Header 0xA5000400 with in_valid toggling 1/0 per cycle over 4 payloads -> 4 enables 0b0001..0b1000 in order, each 1 cycle after its acceptance.
REQ-041 Reset asserted after the 2nd of 4 payloads -> outputs 0 next cycle; a new header then loads correctly.
